// File: rtl/d_ff_pkg.sv
// Purpose : shared constants and helpers for the d_ff_pipe delay line.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package d_ff_pkg;

  // Default reset/flush value for every pipeline stage.
  localparam int unsigned D_FF_RST_VAL_DEF = 0;

  // Fill counter must hold 0..depth inclusive.
  function automatic int d_ff_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/d_ff_pipe_if.sv
// Purpose : bundles the data/control signals of d_ff_pipe (clock and reset stay plain ports).
// Latency : n/a (wiring only).
// Backpressure: none; i_en is the only flow control (stall when low).
// Signals : i_en, i_flush, i_d (into pipe); o_q, o_qbar, o_valid, o_rise, o_fall (out of pipe).
interface d_ff_pipe_if #(
  parameter int WIDTH = 1
);
  logic             i_en;
  logic             i_flush;
  logic [WIDTH-1:0] i_d;
  logic [WIDTH-1:0] o_q;
  logic [WIDTH-1:0] o_qbar;
  logic             o_valid;
  logic [WIDTH-1:0] o_rise;
  logic [WIDTH-1:0] o_fall;

  // Driver side (feeds the pipe, observes its outputs).
  modport master (
    output i_en, i_flush, i_d,
    input  o_q, o_qbar, o_valid, o_rise, o_fall
  );

  // Pipe side.
  modport slave (
    input  i_en, i_flush, i_d,
    output o_q, o_qbar, o_valid, o_rise, o_fall
  );
endinterface

// File: rtl/d_ff_stage.sv
// Purpose : one WIDTH-bit enabled register stage with flush and RST_VAL load.
// Latency : 1 enabled edge from i_d to o_q.
// Backpressure: holds its value while i_en is low.
// Ports   : i_clk, i_rst_n (sync, active-low), i_en, i_flush, i_d -> o_q.
module d_ff_stage #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] dat_d;
  logic [WIDTH-1:0] dat_q;

  // Flush beats enable; reset is handled in the flop block.
  always_comb begin
    dat_d = dat_q;
    if (i_flush)   dat_d = RST_VAL;
    else if (i_en) dat_d = i_d;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) dat_q <= RST_VAL;
    else          dat_q <= dat_d;
  end

  assign o_q = dat_q;

endmodule

// File: rtl/d_ff_pipe.sv
// Purpose : WIDTH x DEPTH enabled register pipeline with flush, fill tracking, true/complement outputs.
// Latency : i_d reaches o_q after exactly DEPTH enabled edges; o_valid after DEPTH enabled edges.
// Backpressure: i_en low freezes data, complement and fill count; no data is lost.
// Ports   : i_clk, i_rst_n (sync, active-low), bus (d_ff_pipe_if.slave).
// Option  : define D_FF_PIPE_EDGE_EN to build per-bit rise/fall pulses; otherwise they read 0.
module d_ff_pipe
  import d_ff_pkg::*;
#(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(D_FF_RST_VAL_DEF)
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  d_ff_pipe_if.slave  bus
);

  localparam int CNT_W = d_ff_cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  // stage_dat[0] is the input; stage_dat[k+1] is the output of stage k.
  logic [WIDTH-1:0] stage_dat [DEPTH+1];

  assign stage_dat[0] = bus.i_d;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    d_ff_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (bus.i_en),
      .i_flush (bus.i_flush),
      .i_d     (stage_dat[g]),
      .o_q     (stage_dat[g+1])
    );
  end

  logic [WIDTH-1:0] qbar_d,  qbar_q;
  logic [CNT_W-1:0] cnt_d,   cnt_q;
  logic             valid_d, valid_q;

  always_comb begin
    qbar_d = qbar_q;
    cnt_d  = cnt_q;
    if (bus.i_flush) begin
      qbar_d = ~RST_VAL;
      cnt_d  = '0;
    end else if (bus.i_en) begin
      // Complement the value the last stage is loading this edge, so
      // o_q and o_qbar change together.
      qbar_d = ~stage_dat[DEPTH-1];
      if (cnt_q != CNT_FULL) cnt_d = cnt_q + 1'b1;
    end
    valid_d = (cnt_d == CNT_FULL);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      qbar_q  <= ~RST_VAL;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      qbar_q  <= qbar_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign bus.o_q     = stage_dat[DEPTH];
  assign bus.o_qbar  = qbar_q;
  assign bus.o_valid = valid_q;

`ifdef D_FF_PIPE_EDGE_EN
  // Shadow of o_q taken every clock (not gated by i_en), so a pulse lasts
  // one clock even when the pipe stalls right after a transition.
  logic [WIDTH-1:0] q_prev_d, q_prev_q;

  always_comb begin
    q_prev_d = stage_dat[DEPTH];
    if (bus.i_flush) q_prev_d = RST_VAL;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) q_prev_q <= RST_VAL;
    else          q_prev_q <= q_prev_d;
  end

  assign bus.o_rise =  stage_dat[DEPTH] & ~q_prev_q & {WIDTH{valid_q}};
  assign bus.o_fall = ~stage_dat[DEPTH] &  q_prev_q & {WIDTH{valid_q}};
`else
  assign bus.o_rise = '0;
  assign bus.o_fall = '0;
`endif

endmodule

// File: tb/tb_d_ff_pipe.sv
// Purpose : scoreboard bench for d_ff_pipe (WIDTH=4, DEPTH=3, RST_VAL=0).
// Latency : expectations are queued per clock edge and checked half a cycle later.
// Backpressure: exercised through i_en stalls.
module tb_d_ff_pipe;

  localparam int         W   = 4;
  localparam int         D   = 3;
  localparam logic [3:0] RV  = 4'h0;
`ifdef D_FF_PIPE_EDGE_EN
  localparam bit         EDGE = 1'b1;
`else
  localparam bit         EDGE = 1'b0;
`endif

  logic clk;
  logic rst_n;

  d_ff_pipe_if #(.WIDTH(W)) bus ();

  d_ff_pipe #(
    .WIDTH   (W),
    .DEPTH   (D),
    .RST_VAL (RV)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] q;
    logic [3:0] qbar;
    logic       valid;
    logic [3:0] rise;
    logic [3:0] fall;
  } exp_t;

  exp_t sb [$];

  int checks = 0;
  int errors = 0;

  // Reference model: the last D accepted samples (oldest first), seeded with
  // RST_VAL; the oldest one is what the output shows.
  logic [3:0] hist [$];
  int         fill;
  logic [3:0] m_q;
  logic [3:0] m_prev;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every clock the DUT presents a full output set; compare it.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("o_q",     bus.o_q,            e.q);
      chk("o_qbar",  bus.o_qbar,         e.qbar);
      chk("o_valid", {3'b0, bus.o_valid}, {3'b0, e.valid});
      chk("o_rise",  bus.o_rise,         e.rise);
      chk("o_fall",  bus.o_fall,         e.fall);
    end
  end

  task automatic model_clear();
    hist.delete();
    for (int i = 0; i < D; i++) hist.push_back(RV);
    fill   = 0;
    m_q    = RV;
    m_prev = RV;
  endtask

  // One clock edge: drive inputs, advance the model, queue the expectation.
  task automatic step(input logic r_n, input logic fl, input logic en, input logic [3:0] d);
    exp_t e;
    @(negedge clk);
    rst_n       = r_n;
    bus.i_flush = fl;
    bus.i_en    = en;
    bus.i_d     = d;
    if (!r_n || fl) begin
      model_clear();
    end else begin
      m_prev = m_q;
      if (en) begin
        hist.push_back(d);
        void'(hist.pop_front());
        if (fill < D) fill++;
      end
      m_q = hist[0];
    end
    e.q     = m_q;
    e.qbar  = ~m_q;
    e.valid = (fill >= D);
    e.rise  = (EDGE && e.valid) ? (m_q & ~m_prev) : 4'h0;
    e.fall  = (EDGE && e.valid) ? (~m_q & m_prev) : 4'h0;
    @(posedge clk);
    sb.push_back(e);
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.i_en    = 1'b1;
    bus.i_flush = 1'b0;
    bus.i_d     = 4'hF;
    model_clear();

    // Reset held two clocks with data present.
    step(1'b0, 1'b0, 1'b1, 4'hF);
    step(1'b0, 1'b0, 1'b1, 4'hF);

    // Latency and fill.
    step(1'b1, 1'b0, 1'b1, 4'hA);
    step(1'b1, 1'b0, 1'b1, 4'h5);
    step(1'b1, 1'b0, 1'b1, 4'hC);
    step(1'b1, 1'b0, 1'b1, 4'h3);
    step(1'b1, 1'b0, 1'b1, 4'h0);
    step(1'b1, 1'b0, 1'b1, 4'h0);

    // Flush while valid, with data F that must not be captured.
    step(1'b1, 1'b1, 1'b1, 4'hF);

    // Enable stall.
    step(1'b1, 1'b0, 1'b1, 4'h7);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 4'(i + 1));
    step(1'b1, 1'b0, 1'b1, 4'h2);
    step(1'b1, 1'b0, 1'b1, 4'h4);

    // Reset beats flush and enable.
    step(1'b0, 1'b1, 1'b1, 4'hF);
    // Mid-fill reset.
    step(1'b1, 1'b0, 1'b1, 4'h1);
    step(1'b1, 1'b0, 1'b1, 4'h2);
    step(1'b0, 1'b0, 1'b1, 4'h3);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 4'h6);

    // Edge pulses: fill with 0, then 0->9, then 9->8.
    step(1'b1, 1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 4'h0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 4'h9);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 4'h8);
    // Transition followed by a stall: pulse must still be one clock.
    step(1'b1, 1'b0, 1'b1, 4'h1);
    step(1'b1, 1'b0, 1'b1, 4'h1);
    step(1'b1, 1'b0, 1'b1, 4'h1);
    step(1'b1, 1'b0, 1'b0, 4'h1);
    step(1'b1, 1'b0, 1'b0, 4'h1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic r_n, fl, en;
      r_n = ($urandom_range(0, 99) >= 2);
      fl  = ($urandom_range(0, 99) < 5);
      en  = ($urandom_range(0, 99) < 70);
      step(r_n, fl, en, 4'($urandom_range(0, 15)));
    end

    // Drain: the monitor must have consumed every expectation.
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
